// File: rtl/proc_pkg.sv
// Shared types and instruction field positions for the processor control FSM.
package proc_pkg;

    localparam int unsigned PkgDw  = 10;
    localparam int unsigned PkgAw  = 2;
    localparam int unsigned PkgOpw = 4;

    // Instruction fields: [3:0] opcode, [5:4] Rx, [7:6] Ry, [9:8] reserved
    localparam int unsigned OpLsb = 0;
    localparam int unsigned RxLsb = 4;
    localparam int unsigned RyLsb = 6;

    typedef enum logic [3:0] {
        OpLoad    = 4'd0,
        OpCopy    = 4'd1,
        OpAdd     = 4'd2,
        OpSub     = 4'd3,
        OpInv     = 4'd4,
        OpXor     = 4'd5,
        OpAddi    = 4'd6,
        OpIllegal = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEx1  = 2'd1,
        StEx2  = 2'd2
    } ctrl_state_t;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluInv = 3'b010,
        AluXor = 3'b011
    } alu_op_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits the instruction register into opcode and
// register fields; opcodes 7-15 all decode to OpIllegal.
module instr_decoder
    import proc_pkg::*;
#(
    parameter int unsigned DW  = PkgDw,
    parameter int unsigned AW  = PkgAw,
    parameter int unsigned OPW = PkgOpw
) (
    input  logic [DW-1:0] ir,
    output opcode_t       opcode,
    output logic [AW-1:0] rx,
    output logic [AW-1:0] ry,
    output logic          is_alu,
    output logic          is_illegal
);

    logic [OPW-1:0] raw_op;
    logic           unused_rsvd;

    assign raw_op      = ir[OpLsb +: OPW];
    assign rx          = ir[RxLsb +: AW];
    assign ry          = ir[RyLsb +: AW];
    assign unused_rsvd = ^ir[DW-1:RyLsb+AW];

    always_comb begin
        opcode     = OpIllegal;
        is_alu     = 1'b0;
        is_illegal = 1'b0;
        case (raw_op)
            4'd0:    opcode = OpLoad;
            4'd1:    opcode = OpCopy;
            4'd2:    begin opcode = OpAdd;  is_alu = 1'b1; end
            4'd3:    begin opcode = OpSub;  is_alu = 1'b1; end
            4'd4:    begin opcode = OpInv;  is_alu = 1'b1; end
            4'd5:    begin opcode = OpXor;  is_alu = 1'b1; end
            4'd6:    begin opcode = OpAddi; is_alu = 1'b1; end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/proc_controller.sv
// Multi-cycle control FSM sequencing the 4x10-bit register file, ALU and bus sources.
// Optional macro PROC_CTRL_RETIRE_CNT_EN adds the RETIRED instruction-retire counter.
module proc_controller
    import proc_pkg::*;
#(
    parameter int unsigned DW  = PkgDw,
    parameter int unsigned AW  = PkgAw,
    parameter int unsigned OPW = PkgOpw
) (
    input  logic          CLKb,
    input  logic          RSTb,
    input  logic          EXEC,
    input  logic [DW-1:0] INSTR,
    output logic          ENW,
    output logic [AW-1:0] WRA,
    output logic          ENR0,
    output logic [AW-1:0] RDA0,
    output logic          ENR1,
    output logic [AW-1:0] RDA1,
    output logic [2:0]    ALU_OP,
    output logic          ALU_LD,
    output logic          IMM_EN,
    output logic          EXT_EN,
    output logic          GOUT,
    output logic          DONE,
`ifdef PROC_CTRL_RETIRE_CNT_EN
    output logic          BUSY,
    output logic [DW-1:0] RETIRED
`else
    output logic          BUSY
`endif
);

    ctrl_state_t   state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;

    opcode_t       opcode;
    logic [AW-1:0] rx, ry;
    logic          is_alu, is_illegal;

    instr_decoder #(
        .DW  (DW),
        .AW  (AW),
        .OPW (OPW)
    ) u_decoder (
        .ir         (ir_q),
        .opcode     (opcode),
        .rx         (rx),
        .ry         (ry),
        .is_alu     (is_alu),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state: IR only loads from IDLE, so EXEC while busy is dropped.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (EXEC) begin
                    ir_d    = INSTR;
                    state_d = StEx1;
                end
            end
            StEx1:   state_d = (is_alu && !is_illegal) ? StEx2 : StIdle;
            StEx2:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend only on state and IR; one bus source at most per cycle.
    always_comb begin
        ENW    = 1'b0;
        WRA    = '0;
        ENR0   = 1'b0;
        RDA0   = '0;
        ENR1   = 1'b0;
        RDA1   = '0;
        ALU_OP = AluAdd;
        ALU_LD = 1'b0;
        IMM_EN = 1'b0;
        EXT_EN = 1'b0;
        GOUT   = 1'b0;
        DONE   = 1'b0;
        BUSY   = (state_q != StIdle);
        unique case (state_q)
            StIdle: ;
            StEx1: begin
                if (is_illegal) begin
                    DONE = 1'b1;
                end else begin
                    unique case (opcode)
                        OpLoad: begin
                            EXT_EN = 1'b1;
                            ENW    = 1'b1;
                            WRA    = rx;
                            DONE   = 1'b1;
                        end
                        OpCopy: begin
                            ENR0 = 1'b1;
                            RDA0 = ry;
                            ENW  = 1'b1;
                            WRA  = rx;
                            DONE = 1'b1;
                        end
                        OpAdd, OpSub, OpInv, OpXor: begin
                            ENR0   = 1'b1;
                            RDA0   = rx;
                            ENR1   = 1'b1;
                            RDA1   = ry;
                            ALU_LD = 1'b1;
                            unique case (opcode)
                                OpSub:   ALU_OP = AluSub;
                                OpInv:   ALU_OP = AluInv;
                                OpXor:   ALU_OP = AluXor;
                                default: ALU_OP = AluAdd;
                            endcase
                        end
                        OpAddi: begin
                            ENR0   = 1'b1;
                            RDA0   = rx;
                            IMM_EN = 1'b1;
                            ALU_LD = 1'b1;
                            ALU_OP = AluAdd;
                        end
                        default: DONE = 1'b1;
                    endcase
                end
            end
            StEx2: begin
                GOUT = 1'b1;
                ENW  = 1'b1;
                WRA  = rx;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PROC_CTRL_RETIRE_CNT_EN
    logic [DW-1:0] retired_q;

    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            retired_q <= '0;
        end else if (DONE) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign RETIRED = retired_q;
`endif

endmodule

// File: tb/tb_proc_controller.sv
// Directed self-checking bench for proc_controller with hand-computed output vectors.
module tb_proc_controller;

    logic       CLKb;
    logic       RSTb;
    logic       EXEC;
    logic [9:0] INSTR;
    logic       ENW, ENR0, ENR1, ALU_LD, IMM_EN, EXT_EN, GOUT, DONE, BUSY;
    logic [1:0] WRA, RDA0, RDA1;
    logic [2:0] ALU_OP;
`ifdef PROC_CTRL_RETIRE_CNT_EN
    logic [9:0] RETIRED;
`endif

    int checks = 0;
    int errors = 0;

    proc_controller dut (
        .CLKb    (CLKb),
        .RSTb    (RSTb),
        .EXEC    (EXEC),
        .INSTR   (INSTR),
        .ENW     (ENW),
        .WRA     (WRA),
        .ENR0    (ENR0),
        .RDA0    (RDA0),
        .ENR1    (ENR1),
        .RDA1    (RDA1),
        .ALU_OP  (ALU_OP),
        .ALU_LD  (ALU_LD),
        .IMM_EN  (IMM_EN),
        .EXT_EN  (EXT_EN),
        .GOUT    (GOUT),
        .DONE    (DONE),
`ifdef PROC_CTRL_RETIRE_CNT_EN
        .BUSY    (BUSY),
        .RETIRED (RETIRED)
`else
        .BUSY    (BUSY)
`endif
    );

    initial CLKb = 1'b0;
    always #5 CLKb = ~CLKb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Order: ENW WRA ENR0 RDA0 ENR1 RDA1 ALU_OP ALU_LD IMM_EN EXT_EN GOUT DONE BUSY
    function automatic logic [31:0] mk(input logic enw, input logic [1:0] wra,
                                       input logic enr0, input logic [1:0] rda0,
                                       input logic enr1, input logic [1:0] rda1,
                                       input logic [2:0] aop, input logic ald,
                                       input logic imm, input logic ext, input logic gout,
                                       input logic done, input logic busy);
        return {14'b0, enw, wra, enr0, rda0, enr1, rda1, aop, ald, imm, ext, gout, done, busy};
    endfunction

    function automatic logic [31:0] obs();
        return {14'b0, ENW, WRA, ENR0, RDA0, ENR1, RDA1, ALU_OP, ALU_LD, IMM_EN, EXT_EN,
                GOUT, DONE, BUSY};
    endfunction

    task automatic step();
        @(posedge CLKb);
        #1;
    endtask

    initial begin
        RSTb  = 1'b0;
        EXEC  = 1'b1;
        INSTR = 10'h020;
        repeat (3) step();
        check("rst_outs", obs(), 32'd0);
        check("rst_busy", {31'b0, BUSY}, 32'd0);
`ifdef PROC_CTRL_RETIRE_CNT_EN
        check("rst_retired", {22'b0, RETIRED}, 32'd0);
`endif
        RSTb = 1'b1;
        EXEC = 1'b0;
        step();
        step();
        check("idle_after_rst", obs(), 32'd0);

        // LOAD R2
        EXEC = 1'b1; INSTR = 10'h020; step(); EXEC = 1'b0;
        check("load_ex1", obs(), mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        step();
        check("load_idle", obs(), 32'd0);

        // ADD R1,R3 with a stray EXEC during EX1
        EXEC = 1'b1; INSTR = 10'h0D2; step();
        INSTR = 10'h020;
        check("add_ex1", obs(), mk(0, 0, 1, 1, 1, 3, 3'b000, 1, 0, 0, 0, 0, 1));
        step(); EXEC = 1'b0;
        check("add_ex2", obs(), mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        step();
        check("add_no_requeue", obs(), 32'd0);

        // ADDI R0,#2 then illegal issued in the cycle right after DONE
        EXEC = 1'b1; INSTR = 10'h086; step(); EXEC = 1'b0;
        check("addi_ex1", obs(), mk(0, 0, 1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 1));
        step();
        EXEC = 1'b1; INSTR = 10'h00F;
        check("addi_ex2", obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        step();
        check("b2b_idle", obs(), 32'd0);
        step(); EXEC = 1'b0;
        check("illegal_f", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step();
        check("illegal_idle", obs(), 32'd0);

        // COPY R2 <- R1
        EXEC = 1'b1; INSTR = 10'h061; step(); EXEC = 1'b0;
        check("copy_ex1", obs(), mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step();

        // XOR R3,R3
        EXEC = 1'b1; INSTR = 10'h0F5; step(); EXEC = 1'b0;
        check("xor_ex1", obs(), mk(0, 0, 1, 3, 1, 3, 3'b011, 1, 0, 0, 0, 0, 1));
        step();
        check("xor_ex2", obs(), mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        step();

        // INV R2,R0
        EXEC = 1'b1; INSTR = 10'h024; step(); EXEC = 1'b0;
        check("inv_ex1", obs(), mk(0, 0, 1, 2, 1, 0, 3'b010, 1, 0, 0, 0, 0, 1));
        step();
        check("inv_ex2", obs(), mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        step();

        // LOAD R1 with reserved bits set
        EXEC = 1'b1; INSTR = 10'h310; step(); EXEC = 1'b0;
        check("load_rsvd", obs(), mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        step();

        // Illegal opcode 7
        EXEC = 1'b1; INSTR = 10'h007; step(); EXEC = 1'b0;
        check("illegal_7", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step();

        // SUB R1,R2 aborted by reset in EX1
        EXEC = 1'b1; INSTR = 10'h093; step(); EXEC = 1'b0;
        check("sub_ex1", obs(), mk(0, 0, 1, 1, 1, 2, 3'b001, 1, 0, 0, 0, 0, 1));
`ifdef PROC_CTRL_RETIRE_CNT_EN
        check("retired_before_abort", {22'b0, RETIRED}, 32'd9);
`endif
        #2 RSTb = 1'b0;
        #1;
        check("sub_async_rst", obs(), 32'd0);
        step();
        RSTb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("sub_no_write", {30'b0, ENW, BUSY}, 32'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
